demux_data: RTL and testbench

- Inverse of the 2:1 eight-lane data selector: steers one 8×256-bit lane group into bank A or bank B of the shuffle/poly-mul 2D array datapath.
- Operates as a ping-pong writer: fills one bank for a burst of BURST_LEN beats, then the other.
- Each bank output has a registered holding stage with valid/ready handshake, so downstream array stalls back-pressure the source.

---
 rtl/demux_data_pkg.sv | 17 +
 rtl/demux_data_if.sv | 32 +++
 rtl/demux_bank_reg.sv | 54 +++++
 rtl/demux_data.sv | 113 +++++++++++
 tb/tb_demux_data.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_data_pkg.sv
// Shared poly-mul datapath constants: lane geometry and bank encoding.
package demux_data_pkg;

  localparam int DW    = 256;
  localparam int LANES = 8;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  // Beat counter width; a one-beat burst still needs a 1-bit counter.
  function automatic int cw_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_data_if.sv
// Lane-group bus between the selector source and the two array banks.
interface demux_data_if #(
  parameter int DW    = demux_data_pkg::DW,
  parameter int LANES = demux_data_pkg::LANES
);
  logic                       force_i;
  logic                       sel_i;
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [LANES-1:0][DW-1:0]   data_i;
  logic                       bank_o;
  logic                       a_valid_o;
  logic                       a_ready_i;
  logic                       a_last_o;
  logic [LANES-1:0][DW-1:0]   data_a_o;
  logic                       b_valid_o;
  logic                       b_ready_i;
  logic                       b_last_o;
  logic [LANES-1:0][DW-1:0]   data_b_o;

  modport master (
    output force_i, sel_i, in_valid_i, data_i, a_ready_i, b_ready_i,
    input  in_ready_o, bank_o, a_valid_o, a_last_o, data_a_o,
           b_valid_o, b_last_o, data_b_o
  );

  modport slave (
    input  force_i, sel_i, in_valid_i, data_i, a_ready_i, b_ready_i,
    output in_ready_o, bank_o, a_valid_o, a_last_o, data_a_o,
           b_valid_o, b_last_o, data_b_o
  );
endinterface

// File: rtl/demux_bank_reg.sv
// Eight-lane holding register with valid/ready/last for one array bank.
module demux_bank_reg #(
  parameter int DW    = demux_data_pkg::DW,
  parameter int LANES = demux_data_pkg::LANES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     load_last,
  input  logic [LANES-1:0][DW-1:0] load_data,
  input  logic                     ready,
  output logic                     valid,
  output logic                     last,
  output logic [LANES-1:0][DW-1:0] data
);
  logic                     valid_r, valid_nxt_s;
  logic                     last_r, last_nxt_s;
  logic [LANES-1:0][DW-1:0] data_r, data_nxt_s;

  // Load wins over drain so a new beat can enter the cycle the old one leaves.
  always_comb begin
    valid_nxt_s = valid_r;
    last_nxt_s  = last_r;
    data_nxt_s  = data_r;
    if (load) begin
      valid_nxt_s = 1'b1;
      last_nxt_s  = load_last;
      data_nxt_s  = load_data;
    end else if (valid_r && ready) begin
      valid_nxt_s = 1'b0;
      last_nxt_s  = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
      last_nxt_s  = last_r;
    end
  end

  // Holding stage state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= {(LANES*DW){1'b0}};
    end else begin
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  assign valid = valid_r;
  assign last  = last_r;
  assign data  = data_r;
endmodule

// File: rtl/demux_data.sv
// Ping-pong lane-group writer: steers input beats into bank A or B in bursts.
module demux_data #(
  parameter int DW        = demux_data_pkg::DW,
  parameter int BURST_LEN = 16,
  parameter int CW        = demux_data_pkg::cw_for(BURST_LEN)
) (
  input  logic         clk,
  input  logic         rst,
  demux_data_if.slave  bus
);
  import demux_data_pkg::*;

  logic [CW-1:0] count_r, count_nxt_s;
  bank_e         bank_r, bank_nxt_s, target_s;
  logic          t_valid_s, t_ready_s, in_ready_s, accept_s, wrap_s;
  logic          load_a_s, load_b_s;
  logic          a_valid_s, b_valid_s;

  // Target bank and its handshake state; forcing overrides the ping-pong pointer.
  always_comb begin
    target_s  = bank_r;
    t_valid_s = a_valid_s;
    t_ready_s = bus.a_ready_i;
    if (bus.force_i) begin
      target_s = bank_e'(bus.sel_i);
    end else begin
      target_s = bank_r;
    end
    case (target_s)
      BANK_A: begin
        t_valid_s = a_valid_s;
        t_ready_s = bus.a_ready_i;
      end
      BANK_B: begin
        t_valid_s = b_valid_s;
        t_ready_s = bus.b_ready_i;
      end
      default: begin
        t_valid_s = a_valid_s;
        t_ready_s = bus.a_ready_i;
      end
    endcase
  end

  assign in_ready_s = ~t_valid_s | t_ready_s;
  assign accept_s   = bus.in_valid_i & in_ready_s;
  assign wrap_s     = (count_r == CW'(BURST_LEN - 1));
  assign load_a_s   = accept_s & (target_s == BANK_A);
  assign load_b_s   = accept_s & (target_s == BANK_B);

  // Burst counter and bank pointer; forced beats record the bank so auto mode resumes there.
  always_comb begin
    count_nxt_s = count_r;
    bank_nxt_s  = bank_r;
    if (accept_s) begin
      if (wrap_s) begin
        count_nxt_s = {CW{1'b0}};
      end else begin
        count_nxt_s = count_r + CW'(1'b1);
      end
      if (bus.force_i) begin
        bank_nxt_s = bank_e'(bus.sel_i);
      end else if (wrap_s) begin
        bank_nxt_s = (bank_r == BANK_A) ? BANK_B : BANK_A;
      end else begin
        bank_nxt_s = bank_r;
      end
    end else begin
      count_nxt_s = count_r;
      bank_nxt_s  = bank_r;
    end
  end

  // Counter and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
      bank_r  <= BANK_A;
    end else begin
      count_r <= count_nxt_s;
      bank_r  <= bank_nxt_s;
    end
  end

  demux_bank_reg #(.DW(DW), .LANES(LANES)) u_bank_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a_s),
    .load_last (wrap_s),
    .load_data (bus.data_i),
    .ready     (bus.a_ready_i),
    .valid     (a_valid_s),
    .last      (bus.a_last_o),
    .data      (bus.data_a_o)
  );

  demux_bank_reg #(.DW(DW), .LANES(LANES)) u_bank_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b_s),
    .load_last (wrap_s),
    .load_data (bus.data_i),
    .ready     (bus.b_ready_i),
    .valid     (b_valid_s),
    .last      (bus.b_last_o),
    .data      (bus.data_b_o)
  );

  assign bus.in_ready_o = in_ready_s;
  assign bus.a_valid_o  = a_valid_s;
  assign bus.b_valid_o  = b_valid_s;
  assign bus.bank_o     = bank_r;
endmodule

// File: tb/tb_demux_data.sv
// Bench for demux_data: BURST_LEN=4 and BURST_LEN=1 instances share one stimulus
// stream and are scored against a per-bank beat-queue model.
module tb_demux_data;
  typedef struct packed {
    logic             last;
    logic [7:0][255:0] data;
  } beat_t;

  logic clk;
  logic rst;
  logic force_v, sel_v, in_valid_v, a_rdy_v, b_rdy_v;
  logic [7:0][255:0] data_v;

  int n_cmp = 0;
  int n_bad = 0;

  demux_data_if #(.DW(256)) if4 ();
  demux_data_if #(.DW(256)) if1 ();

  demux_data #(.DW(256), .BURST_LEN(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  demux_data #(.DW(256), .BURST_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if4.force_i = force_v;    assign if1.force_i = force_v;
  assign if4.sel_i = sel_v;        assign if1.sel_i = sel_v;
  assign if4.in_valid_i = in_valid_v; assign if1.in_valid_i = in_valid_v;
  assign if4.data_i = data_v;      assign if1.data_i = data_v;
  assign if4.a_ready_i = a_rdy_v;  assign if1.a_ready_i = a_rdy_v;
  assign if4.b_ready_i = b_rdy_v;  assign if1.b_ready_i = b_rdy_v;

  logic rdy_w [2];
  logic bank_w [2];
  logic vld_w [2][2];
  logic lst_w [2][2];
  logic [7:0][255:0] dat_w [2][2];

  assign rdy_w[0] = if4.in_ready_o;  assign rdy_w[1] = if1.in_ready_o;
  assign bank_w[0] = if4.bank_o;     assign bank_w[1] = if1.bank_o;
  assign vld_w[0][0] = if4.a_valid_o; assign vld_w[0][1] = if4.b_valid_o;
  assign vld_w[1][0] = if1.a_valid_o; assign vld_w[1][1] = if1.b_valid_o;
  assign lst_w[0][0] = if4.a_last_o;  assign lst_w[0][1] = if4.b_last_o;
  assign lst_w[1][0] = if1.a_last_o;  assign lst_w[1][1] = if1.b_last_o;
  assign dat_w[0][0] = if4.data_a_o;  assign dat_w[0][1] = if4.data_b_o;
  assign dat_w[1][0] = if1.data_a_o;  assign dat_w[1][1] = if1.data_b_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int bl(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Model: each bank holds a queue of beats it still owes downstream.
  beat_t q [2][2][$];
  int    nbeats [2];
  logic  mbank [2];
  bit    model_on = 1'b0;

  initial begin : compare_proc
    logic  t;
    logic  er;
    beat_t bt;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        t  = force_v ? sel_v : mbank[d];
        er = (q[d][t].size() == 0) || (t ? b_rdy_v : a_rdy_v);
        if (model_on) begin
          chk($sformatf("d%0d in_ready", d), rdy_w[d], er);
          chk($sformatf("d%0d bank", d), bank_w[d], mbank[d]);
          for (int b = 0; b < 2; b++) begin
            chk($sformatf("d%0d bank%0d valid", d, b), vld_w[d][b], q[d][b].size() != 0);
            if (q[d][b].size() != 0) begin
              bt = q[d][b][0];
              chk($sformatf("d%0d bank%0d last", d, b), lst_w[d][b], bt.last);
              for (int l = 0; l < 8; l++)
                chk($sformatf("d%0d bank%0d lane%0d", d, b, l), dat_w[d][b][l], bt.data[l]);
            end
          end
        end
        if (rst) begin
          q[d][0].delete();
          q[d][1].delete();
          nbeats[d] = 0;
          mbank[d]  = 1'b0;
        end else if (model_on) begin
          for (int b = 0; b < 2; b++)
            if (q[d][b].size() != 0 && ((b == 0) ? a_rdy_v : b_rdy_v))
              void'(q[d][b].pop_front());
          if (in_valid_v && er) begin
            bt.last = ((nbeats[d] % bl(d)) == bl(d) - 1);
            bt.data = data_v;
            q[d][t].push_back(bt);
            if (force_v) mbank[d] = sel_v;
            else if (bt.last) mbank[d] = ~mbank[d];
            nbeats[d]++;
          end
        end
      end
      if (rst) model_on = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k);
    in_valid_v = 1'b1;
    for (int l = 0; l < 8; l++) data_v[l] = 256'(k);
  endtask

  initial begin : stim
    rst = 1'b1; force_v = 1'b0; sel_v = 1'b0; in_valid_v = 1'b0;
    a_rdy_v = 1'b1; b_rdy_v = 1'b1; data_v = '0;
    tick(); tick(); tick();
    rst = 1'b0;

    // Auto ping-pong, both banks ready, lanes carry the beat index.
    for (int k = 0; k < 8; k++) begin
      put(k);
      tick();
      if (k == 0) begin
        chk("t1 a_valid k0", if4.a_valid_o, 1'b1);
        chk("t1 a lane0 k0", if4.data_a_o[0], 256'd0);
        chk("t6 a_last k0", if1.a_last_o, 1'b1);
        chk("t6 bank k0", if1.bank_o, 1'b1);
      end
      if (k == 1) begin
        chk("t6 b_valid k1", if1.b_valid_o, 1'b1);
        chk("t6 b lane0 k1", if1.data_b_o[0], 256'd1);
        chk("t6 b_last k1", if1.b_last_o, 1'b1);
        chk("t6 bank k1", if1.bank_o, 1'b0);
      end
      if (k == 3) begin
        chk("t1 a_last k3", if4.a_last_o, 1'b1);
        chk("t1 a lane7 k3", if4.data_a_o[7], 256'd3);
        chk("t1 bank k3", if4.bank_o, 1'b1);
      end
      if (k == 4) begin
        chk("t1 b_valid k4", if4.b_valid_o, 1'b1);
        chk("t1 b lane0 k4", if4.data_b_o[0], 256'd4);
        chk("t1 a_valid k4", if4.a_valid_o, 1'b0);
        chk("t1 b_last k4", if4.b_last_o, 1'b0);
      end
      if (k == 7) begin
        chk("t1 b_last k7", if4.b_last_o, 1'b1);
        chk("t1 b lane0 k7", if4.data_b_o[0], 256'd7);
        chk("t1 bank k7", if4.bank_o, 1'b0);
      end
    end
    in_valid_v = 1'b0;
    tick();

    // Bank A stall back-pressures the input, then drain and reload in one cycle.
    a_rdy_v = 1'b0;
    put(100);
    tick();
    put(101);
    #1;
    chk("t2 in_ready stalled", if4.in_ready_o, 1'b0);
    tick();
    chk("t2 a hold", if4.data_a_o[0], 256'd100);
    chk("t2 in_ready still", if4.in_ready_o, 1'b0);
    a_rdy_v = 1'b1;
    #1;
    chk("t2 in_ready released", if4.in_ready_o, 1'b1);
    tick();
    chk("t2 a_valid kept", if4.a_valid_o, 1'b1);
    chk("t2 a reload", if4.data_a_o[0], 256'd101);

    // A stalled while B is targeted.
    a_rdy_v = 1'b0; force_v = 1'b1; sel_v = 1'b1;
    put(102);
    tick();
    chk("t3 b lane0 102", if4.data_b_o[0], 256'd102);
    chk("t3 a held 101", if4.data_a_o[0], 256'd101);
    put(103);
    tick();
    chk("t3 b lane0 103", if4.data_b_o[0], 256'd103);
    chk("t3 b_last 103", if4.b_last_o, 1'b1);
    chk("t3 a still 101", if4.data_a_o[0], 256'd101);
    chk("t3 bank forced", if4.bank_o, 1'b1);
    in_valid_v = 1'b0; a_rdy_v = 1'b1; force_v = 1'b0;
    tick();

    // Forced bank B for six beats, then release to auto mid-burst.
    rst = 1'b1;
    tick();
    rst = 1'b0; force_v = 1'b1; sel_v = 1'b1;
    for (int k = 200; k < 206; k++) begin
      put(k);
      tick();
      chk($sformatf("t4 b lane0 %0d", k), if4.data_b_o[0], 256'(k));
      chk($sformatf("t4 b_last %0d", k), if4.b_last_o, k == 203);
      chk($sformatf("t4 bank %0d", k), if4.bank_o, 1'b1);
    end
    force_v = 1'b0;
    put(206);
    tick();
    chk("t4 b lane0 206", if4.data_b_o[0], 256'd206);
    chk("t4 b_last 206", if4.b_last_o, 1'b0);
    put(207);
    tick();
    chk("t4 b_last 207", if4.b_last_o, 1'b1);
    chk("t4 bank toggled", if4.bank_o, 1'b0);
    in_valid_v = 1'b0;
    tick();

    // Reset with both banks holding beats.
    a_rdy_v = 1'b0; b_rdy_v = 1'b0; force_v = 1'b1; sel_v = 1'b0;
    put(300);
    tick();
    sel_v = 1'b1;
    put(301);
    tick();
    in_valid_v = 1'b0;
    chk("t5 a_valid pre", if4.a_valid_o, 1'b1);
    chk("t5 b_valid pre", if4.b_valid_o, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5 a_valid rst", if4.a_valid_o, 1'b0);
    chk("t5 b_valid rst", if4.b_valid_o, 1'b0);
    chk("t5 bank rst", if4.bank_o, 1'b0);
    rst = 1'b0; force_v = 1'b0; a_rdy_v = 1'b1; b_rdy_v = 1'b1;
    put(302);
    tick();
    chk("t5 a lane0 302", if4.data_a_o[0], 256'd302);
    chk("t5 a_last 302", if4.a_last_o, 1'b0);
    in_valid_v = 1'b0;
    tick();

    // Random traffic scored by the model.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      force_v    = ($urandom_range(0, 3) == 0);
      sel_v      = $urandom_range(0, 1);
      in_valid_v = ($urandom_range(0, 3) != 0);
      a_rdy_v    = ($urandom_range(0, 3) != 0);
      b_rdy_v    = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < 8; l++)
        for (int w = 0; w < 8; w++) data_v[l][w*32 +: 32] = $urandom();
      tick();
    end
    rst = 1'b0; in_valid_v = 1'b0; a_rdy_v = 1'b1; b_rdy_v = 1'b1;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
